// File: rtl/decoder_scan_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Brief    : Shared mode and state encodings for the scanning one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    typedef enum logic [1:0] {
        DIRECT    = 2'b00,
        SCAN_UP   = 2'b01,
        SCAN_DOWN = 2'b10,
        SWEEP     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        HOLD = 2'b01,
        RUN  = 2'b10
    } state_e;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_scan_n_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : onehot_dec
// Brief    : Combinational SEL_W to 2**SEL_W one-hot decode, all-zero when
//            disabled.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   y
);

    localparam int c_OUT_W = 1 << SEL_W;

    always_comb begin
        y = '0;
        if (en) begin
            y = c_OUT_W'(1) << sel;
        end
    end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/decoder_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : decoder_scan_n
// Brief    : Registered one-hot decoder with static hold and a dwell-timed
//            up/down/sweep scan sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    busy,
    output logic                    wrap,
    output logic                    done
);

    localparam int c_OUT_W = 1 << SEL_W;

    state_e                 r_state, w_state_nxt;
    mode_e                  r_mode,  w_mode_nxt;
    logic [SEL_W-1:0]       r_idx,   w_idx_nxt;
    logic [DWELL_W-1:0]     r_dwell, w_dwell_nxt;
    logic [DWELL_W-1:0]     r_cnt,   w_cnt_nxt;
    logic                   r_wrap,  w_wrap_nxt;
    logic                   r_done,  w_done_nxt;
    logic [c_OUT_W-1:0]     r_y,     w_dec;
    logic                   w_dec_en;

    // State register, including the output register that follows the decoder
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OFF;
            r_mode  <= DIRECT;
            r_idx   <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_idx   <= w_idx_nxt;
            r_dwell <= w_dwell_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
            r_done  <= w_done_nxt;
            r_y     <= w_dec;
        end
    end

    // Next-state: en low beats load, load beats dwell stepping
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = OFF;
            w_cnt_nxt   = '0;
        end else if (load) begin
            w_idx_nxt   = sel;
            w_mode_nxt  = mode_e'(mode);
            w_dwell_nxt = dwell;
            w_cnt_nxt   = '0;
            w_state_nxt = (mode_e'(mode) == DIRECT) ? HOLD : RUN;
        end else if (r_state == RUN) begin
            if (r_cnt != r_dwell) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else begin
                w_cnt_nxt = '0;
                case (r_mode)
                    SCAN_UP: begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_wrap_nxt = &r_idx;
                    end
                    SCAN_DOWN: begin
                        w_idx_nxt  = r_idx - 1'b1;
                        w_wrap_nxt = ~|r_idx;
                    end
                    SWEEP: begin
                        if (&r_idx) begin
                            w_state_nxt = OFF;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                    default: begin
                        w_idx_nxt = r_idx;
                    end
                endcase
            end
        end
    end

    // Output decode works on next-state values so y lands with its index
    always_comb begin
        w_dec_en = (w_state_nxt != OFF);
    end

    onehot_dec #(
        .SEL_W (SEL_W)
    ) u_dec (
        .en  (w_dec_en),
        .sel (w_idx_nxt),
        .y   (w_dec)
    );

    assign y    = r_y;
    assign idx  = r_idx;
    assign busy = (r_state == RUN);
    assign wrap = r_wrap;
    assign done = r_done;

endmodule : decoder_scan_n
`default_nettype wire

// File: tb/tb_decoder_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_scan_n
// Brief    : Directed self-checking bench for decoder_scan_n (SEL_W=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       load;
    logic [7:0] dwell;
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy;
    logic       wrap;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    decoder_scan_n #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .load  (load),
        .dwell (dwell),
        .y     (y),
        .idx   (idx),
        .busy  (busy),
        .wrap  (wrap),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] ey, input logic [2:0] eidx,
                           input logic ebusy, input logic ewrap, input logic edone);
        chk({tag, ".y"},    32'(y),    32'(ey));
        chk({tag, ".idx"},  32'(idx),  32'(eidx));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
        chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
        chk({tag, ".done"}, 32'(done), 32'(edone));
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en    = 1'($urandom);
            mode  = 2'($urandom);
            sel   = 3'($urandom);
            load  = 1'($urandom);
            dwell = 8'($urandom);
            tick();
        end
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b1; load = 1'b0; mode = 2'b00; sel = 3'd0; dwell = 8'd0;
        tick();
        chk_all("release", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // DIRECT
        mode = 2'b00; sel = 3'd5; load = 1'b1;
        tick();
        chk_all("direct5", 8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_all("direct5_hold", 8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
        sel = 3'd2;
        tick();
        chk_all("direct_nochg", 8'h20, 3'd5, 1'b0, 1'b0, 1'b0);
        load = 1'b1;
        tick();
        chk_all("direct2", 8'h04, 3'd2, 1'b0, 1'b0, 1'b0);
        load = 1'b0;

        // SCAN_UP, dwell=1, wrap
        mode = 2'b01; dwell = 8'd1; sel = 3'd6; load = 1'b1;
        tick();
        chk_all("up6a", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_all("up6b", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("up7a", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("up7b", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("up0_wrap", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("up0b", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);

        // SCAN_DOWN, dwell=0
        mode = 2'b10; dwell = 8'd0; sel = 3'd1; load = 1'b1;
        tick();
        chk_all("dn1", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_all("dn0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("dn7_wrap", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("dn6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);

        // SWEEP from 5, dwell=0
        mode = 2'b11; dwell = 8'd0; sel = 3'd5; load = 1'b1;
        tick();
        chk_all("sw5", 8'h20, 3'd5, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_all("sw6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("sw7", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("sw_done", 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("sw_after", 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);

        // SWEEP loaded at the last index, dwell=2
        mode = 2'b11; dwell = 8'd2; sel = 3'd7; load = 1'b1;
        tick();
        chk_all("sw_last_a", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_all("sw_last_b", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("sw_last_c", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("sw_last_done", 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);

        // Abort: en low beats load
        mode = 2'b01; dwell = 8'd3; sel = 3'd0; load = 1'b1;
        tick();
        chk_all("ab_up0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        en = 1'b0; load = 1'b1; sel = 3'd4;
        tick();
        chk_all("ab_off", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b1; load = 1'b0;
        tick();
        chk_all("ab_stay_off", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        mode = 2'b00; sel = 3'd3; load = 1'b1;
        tick();
        chk_all("ab_direct3", 8'h08, 3'd3, 1'b0, 1'b0, 1'b0);
        load = 1'b0;

        // rst mid-RUN, right before a sweep would complete
        mode = 2'b11; dwell = 8'd0; sel = 3'd6; load = 1'b1;
        tick();
        chk_all("rs_sw6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_all("rs_sw7", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_all("rs_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("rs_after", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decoder_scan_n
`default_nettype wire

// File: doc/decoder_scan_n.md
# decoder_scan_n

Parametrised, registered N-to-2^N one-hot decoder with enable and a built-in scan sequencer. A load pulse either holds a static decoded select line (DIRECT) or starts an auto-stepping scan with a programmable dwell time: continuous up, continuous down, or a one-shot sweep. It drives one-hot select/strobe banks (LED rows, bank enables, mux selects) where the select must either sit still or walk through all lines.

## Interface
- SEL_W, 3, select code width; OUT_W = 2**SEL_W is derived, not overridable
- DWELL_W, 8, dwell counter width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; low forces the block OFF
- mode  in  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 SWEEP; sampled only on load
- sel  in  SEL_W  start/static index; sampled only on load
- load  in  1  single-cycle start/restart strobe
- dwell  in  DWELL_W  each index is shown for dwell+1 cycles; sampled only on load
- y  out  OUT_W  registered one-hot output, or all-zero
- idx  out  SEL_W  registered current index
- busy  out  1  high while in RUN
- wrap  out  1  one-cycle pulse on the first cycle after a continuous scan wraps
- done  out  1  one-cycle pulse on the first cycle after a sweep completes

## Operation
- Registers: state, idx, mode_q, dwell_q, cnt (DWELL_W).
- States:
  - OFF: y=0.
  - HOLD: y=onehot(idx), static.
  - RUN: y=onehot(idx), stepping.
- Priority, highest first: rst, en=0, load, dwell step.
- rst: state=OFF, idx=0, cnt=0, mode_q=DIRECT, dwell_q=0. All outputs are 0.
- en=0 in any state: next state OFF, cnt=0. idx, mode_q and dwell_q are retained. load is ignored.
- load with en=1 in any state:
  - idx<=sel, mode_q<=mode, dwell_q<=dwell, cnt<=0.
  - Next state is HOLD if mode=DIRECT, otherwise RUN.
- OFF or HOLD without load: state, idx and y are unchanged. Changes on sel, mode and dwell have no effect.
- RUN, no load:
  - If cnt != dwell_q: cnt<=cnt+1.
  - If cnt == dwell_q: cnt<=0 and idx steps per mode_q.
- Step rules:
  - SCAN_UP: idx+1; OUT_W-1 wraps to 0 with wrap=1.
  - SCAN_DOWN: idx-1; 0 wraps to OUT_W-1 with wrap=1.
  - SWEEP: idx+1 while idx < OUT_W-1. At the step point with idx = OUT_W-1: next state OFF, idx unchanged, done=1.
- dwell=0 steps every cycle.
- A sweep loaded with sel=OUT_W-1 shows that index for dwell+1 cycles, then completes.
- Index arithmetic is modulo 2^SEL_W. No out-of-range index exists.
- The y default case is all-zero. y is never X after reset.

## Timing
- All outputs are registered and change only on a clk rising edge.
- Load sampled at edge t: y=onehot(sel) and idx=sel from t+1 onward. busy=1 from t+1 if the mode is not DIRECT.
- Each index is visible for exactly dwell_q+1 cycles in RUN.
- wrap and done are asserted in the same cycle as the new y value (index 0/OUT_W-1 for wrap, all-zero for done), for exactly one cycle.
- done cycle: busy=0, y=0.
- en falling, sampled at edge t: y=0 and busy=0 from t+1. A wrap or done pending at that edge is suppressed.
- load during RUN restarts on the next cycle. It does not complete the current dwell, and it produces no wrap or done.
- rst mid-RUN: all outputs are 0 from the next cycle. No done is generated.

## Structure
- Package decoder_pkg holds:
  - mode_e: DIRECT, SCAN_UP, SCAN_DOWN, SWEEP, encoded 2'b00..2'b11.
  - state_e: OFF, HOLD, RUN.
- Sub-module onehot_dec: combinational SEL_W to 2**SEL_W decode with an enable input; the enable-low output is all-zero.
- Top module: FSM, dwell counter and index stepper. The output register sits after onehot_dec.

## Test plan
All scenarios use SEL_W=3, DWELL_W=8.
- Reset: rst=1 for 2 cycles with random inputs -> y=0, idx=0, busy=wrap=done=0. Release with no load -> y stays 0.
- DIRECT: en=1, mode=00, sel=5, one-cycle load -> y=0x20 next cycle and held. Changing sel to 2 without load -> y stays 0x20. A second load with sel=2 -> y=0x04.
- SCAN_UP with wrap: mode=01, dwell=1, sel=6, load -> y=0x40 for 2 cycles, 0x80 for 2 cycles, then 0x01 with wrap=1 in its first cycle only. busy=1 throughout.
- SCAN_DOWN: mode=10, dwell=0, sel=1 -> y=0x02, 0x01, then 0x80 with wrap=1, then 0x40.
- SWEEP: mode=11, dwell=0, sel=5 -> y=0x20, 0x40, 0x80 with busy=1. Next cycle y=0, busy=0, done=1. Following cycle done=0.
- Abort and priority:
  - Mid SCAN_UP, drop en while pulsing load -> y=0, busy=0 next cycle; the load is ignored.
  - en=1, load sel=3 mode=00 -> y=0x08.
  - rst asserted mid-RUN -> y=0, no done.
